// File: rtl/ff_pipe.sv
// DEPTH-stage, WIDTH-bit register pipeline with valid/ready on both ends.
// Bubbles collapse forward, flush clears all valid bits, occupancy tracks valid stages.
`timescale 1ns/1ps
module ff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  function automatic logic [OW-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [OW-1:0] cnt;
    cnt = {OW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OW'(bits[i]);
    end
    return cnt;
  endfunction

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r    [DEPTH];
  logic [OW-1:0]    occ_r;
  logic [DEPTH-1:0] adv_s;
  logic [DEPTH-1:0] up_v_s;
  logic [WIDTH-1:0] up_d_s [DEPTH];
  logic [DEPTH-1:0] v_nxt_s;
  logic             take_s;

  // Advance enables ripple from the output end: a stage moves if it is empty or the next one moves.
  always_comb begin
    logic carry;
    adv_s          = {DEPTH{1'b0}};
    carry          = ~v_r[DEPTH-1] | out_ready;
    adv_s[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry    = ~v_r[i] | carry;
      adv_s[i] = carry;
    end
  end

  assign in_ready = adv_s[0] & ~flush & ~rst;
  assign take_s   = in_valid & in_ready;

  // Upstream valid/data feeding each stage.
  always_comb begin
    up_v_s    = {DEPTH{1'b0}};
    up_v_s[0] = take_s;
    up_d_s[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v_s[i] = v_r[i-1];
      up_d_s[i] = d_r[i-1];
    end
  end

  // Next valid bits; flush wins over any movement.
  always_comb begin
    v_nxt_s = {DEPTH{1'b0}};
    if (flush) begin
      v_nxt_s = {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        v_nxt_s[i] = adv_s[i] ? up_v_s[i] : v_r[i];
      end
    end
  end

  // Valid bits and occupancy counter, kept in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r   <= {DEPTH{1'b0}};
      occ_r <= {OW{1'b0}};
    end else begin
      v_r   <= v_nxt_s;
      occ_r <= popcount(v_nxt_s);
    end
  end

  // Data registers only load real items, so they stay quiet across bubbles and flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d_r[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (~flush & adv_s[i] & up_v_s[i]) begin
          d_r[i] <= up_d_s[i];
        end else begin
          d_r[i] <= d_r[i];
        end
      end
    end
  end

  assign out_valid = v_r[DEPTH-1];
  assign out_data  = d_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: tb/tb_ff_pipe.sv
// Scoreboard bench for ff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5).
`timescale 1ns/1ps
module tb_ff_pipe;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'hA5;

  logic       clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [7:0] in_data = 8'h00;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  int tests = 0, fails = 0, cyc = 0, out_cnt = 0, stall_cnt = 0;
  logic [7:0] q[$];

  ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %0h, expected no output", out_data);
      end else begin
        check("sb_data", out_data, q.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) stall_cnt++;
    if (!in_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic measure_lat(input string name);
    int n = 0;
    int c0;
    @(negedge clk);
    while (!(in_valid && in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    c0 = cyc;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, cyc - c0, DEPTH);
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    // Reset asserted between edges: outputs must go to reset values at once.
    #12;
    rst = 1'b1;
    #1;
    check("rst_out_data", out_data, RV);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_occ", occupancy, 0);
    @(posedge clk);
    #1;

    // Streaming 0x01..0x10 back-to-back.
    out_ready = 1'b1;
    base      = out_cnt;
    stall_cnt = 0;
    fork
      begin
        for (int i = 1; i <= 16; i++) push(8'(i));
      end
      measure_lat("stream_latency");
    join
    check("stream_no_stall", stall_cnt, 0);
    drain("stream_drain");
    check("stream_count", out_cnt - base, 16);

    // Backpressure: four items fill the pipe, fifth held upstream.
    out_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    check("bp_occ_full", occupancy, 4);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_data", out_data, 8'h11);
    @(posedge clk);
    #1;
    check("bp_still_held", occupancy, 4);
    out_ready = 1'b1;
    #1;
    check("bp_pass_ready", in_ready, 1);
    push(8'h55);
    check("bp_occ_swap", occupancy, 4);
    drain("bp_drain");

    // Bubble collapse with output stalled.
    out_ready = 1'b0;
    push(8'h07);
    repeat (2) @(posedge clk);
    #1;
    push(8'h08);
    repeat (3) @(posedge clk);
    #1;
    check("bub_occ", occupancy, 2);
    check("bub_in_ready", in_ready, 1);
    check("bub_out_valid", out_valid, 1);
    check("bub_out_data", out_data, 8'h07);
    drain("bub_drain");

    // Flush with three items held and a competing input.
    out_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    check("fl_occ_pre", occupancy, 3);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    flush    = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    check("fl_occ_post", occupancy, 0);
    check("fl_out_valid", out_valid, 0);
    out_ready = 1'b1;
    fork
      push(8'h99);
      measure_lat("fl_latency");
    join
    drain("fl_drain");

    // Reset pulse while full and stalled: nothing stale may emerge afterwards.
    out_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, RV);
    check("mid_rst_occ", occupancy, 0);
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    base      = out_cnt;
    repeat (10) @(negedge clk);
    check("mid_rst_no_stale", out_cnt - base, 0);
    check("mid_rst_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ff_pipe.md
Name: ff_pipe

Overview:
- Parametrised successor to the single D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake on both ends.
- Bubbles collapse: an empty stage always accepts new data, even when the output is stalled.
- Supports synchronous flush and reports live occupancy.
- Used as a retiming/delay line between datapath blocks that need backpressure.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data holds a valid item.
- out_ready  input  1  downstream accepts the item this cycle.
- out_data  output  WIDTH  data from the last stage.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State:
  - Per stage i (0 = input side, DEPTH-1 = output side): valid bit v[i] and data register d[i].
  - out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Reset (rst=1, asynchronous):
  - All v=0 and all d=RESET_VAL immediately, without waiting for a clock edge.
  - out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready=0 while rst is high.
  - A reset asserted mid-stream discards all items with no partial output.
- Advance enables (combinational):
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1] for i < DEPTH-1.
  - in_ready = adv[0] & !flush & !rst.
- Stage update on a rising edge, when adv[i]=1:
  - v[i] <= upstream valid. Upstream is v[i-1]; for stage 0 it is in_valid & in_ready.
  - d[i] <= upstream data, but only when upstream valid=1. Otherwise d[i] holds, so data does not toggle on bubbles.
- Stage hold: when adv[i]=0, the stage holds v[i] and d[i].
- Handshakes:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data is stable and out_valid stays high.
- Latency and throughput:
  - On an empty pipe with out_ready=1, an item accepted in cycle N is presented at the output (out_valid=1) in cycle N+DEPTH.
  - Sustained throughput is 1 item per cycle.
  - With the output stalled, the pipe absorbs exactly DEPTH items; then in_ready=0.
- Full pipe (all v=1):
  - in_ready = out_ready (pass-through accept).
  - Simultaneous input and output transfer in the same cycle keeps occupancy unchanged.
- Flush (synchronous, priority over input):
  - On the edge where flush=1, all v <= 0 and no input is accepted; d registers hold.
  - An output transfer in the flush cycle is legal and counts as delivered.
  - occupancy=0 in the following cycle.
- occupancy:
  - Registered-consistent popcount of v, i.e. it reflects the current v bits.
  - Range 0..DEPTH.
- DEPTH=1: degenerates to a single registered stage with the same rules.
- Ordering: items exit in strict FIFO order; none are dropped or duplicated except by flush or rst.

Test Plan:
- Reset/idle: assert rst mid-clock with WIDTH=8, RESET_VAL=8'hA5 → out_data=8'hA5 and out_valid=0 at once, before any edge. Release rst → in_ready=1, occupancy=0.
- Streaming: out_ready=1, push 0x01..0x10 back-to-back with DEPTH=4 → first out_valid 4 cycles after the 0x01 accept. Then 16 consecutive outputs 0x01..0x10, in_ready constantly 1.
- Backpressure:
  - With out_ready=0, push 0x11, 0x22, 0x33, 0x44 → occupancy=4 and in_ready=0; the 5th item 0x55 is held upstream.
  - Raise out_ready → 0x11 is output first, in_ready=1 in the same cycle, and 0x55 is accepted.
- Bubble collapse: out_ready=0, push 0x07 into an empty pipe, wait 2 cycles, push 0x08 → both items packed at the output end. Occupancy=2, in_ready remains 1.
- Flush: pipe holds 3 items and flush=1 with in_valid=1 → in_ready=0 that cycle and the input item is not taken. Occupancy=0 and out_valid=0 next cycle; the next push of 0x99 appears after DEPTH cycles.
- Reset mid-operation: pipe full and stalled, pulse rst for 1 ns between edges → all valids clear immediately and out_data=RESET_VAL. After release, no stale item ever appears at the output.
